imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter XLEN, default 64: width of fetch addresses and returned PC.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit instruction words stored.
REQ-003 SHALL have parameter LATENCY, default 2, legal range 1..4: cycles from request acceptance to earliest response.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1 bit: fetch request present.
REQ-007 SHALL have port req_ready, output, 1 bit: block can accept a request this cycle.
REQ-008 SHALL have port req_addr, input, XLEN bits: byte address of the fetch, i.e. the current PC.
REQ-009 SHALL have port flush, input, 1 bit: branch/jump redirect; discard all outstanding fetches.
REQ-010 SHALL have port rsp_valid, output, 1 bit: response present.
REQ-011 SHALL have port rsp_ready, input, 1 bit: downstream (IF/ID) accepts the response.
REQ-012 SHALL have port rsp_instr, output, 32 bits: fetched instruction.
REQ-013 SHALL have port rsp_pc, output, XLEN bits: req_addr of the request that produced this response.
REQ-014 SHALL have port rsp_err, output, 1 bit: fetch was misaligned or out of range.
REQ-015 SHALL have port load_we, input, 1 bit: preload write enable.
REQ-016 SHALL have port load_addr, input, XLEN bits: preload byte address; bits [1:0] ignored.
REQ-017 SHALL have port load_data, input, 32 bits: preload word.

Function
REQ-018 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1.
REQ-019 SHALL hold at most 4 outstanding requests (in flight plus queued) and SHALL drive req_ready=1 iff outstanding<4, flush=0 and reset=0.
REQ-020 SHALL capture the memory word at index req_addr[..:2] on the acceptance edge; the pipeline carries pc, instr and err.
REQ-021 SHALL make a response visible no earlier than LATENCY cycles after the acceptance edge; with LATENCY=1 and the queue empty, rsp_valid=1 in the cycle after acceptance.
REQ-022 SHALL return responses strictly in acceptance order; there SHALL be no drop and no duplication.
REQ-023 SHALL complete a response on a rising edge where rsp_valid=1 and rsp_ready=1; rsp_instr, rsp_pc and rsp_err SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-024 SHALL use a 4-entry output queue so that back-pressure never loses an in-flight response.
REQ-025 SHALL return full throughput, one response per cycle, when req_valid=1 and rsp_ready=1 continuously.
REQ-026 SHALL set rsp_err=1 and rsp_instr=32'h00000013 (NOP) when req_addr[1:0]!=0 or the word index >= DEPTH_WORDS.
REQ-027 SHALL, when a request is accepted and a response completes on the same edge, leave the outstanding count unchanged.
REQ-028 SHALL, when flush=1 on an edge, empty the pipeline and queue, force outstanding=0, and accept no request on that edge; rsp_valid=0 in the following cycle.
REQ-029 SHALL give flush priority over a response completing on the same edge; that response counts as delivered.
REQ-030 SHALL write load_data to the word at load_addr[..:2] on an edge where load_we=1; an out-of-range load_addr SHALL be ignored.
REQ-031 SHALL, when a load write and a request acceptance hit the same word on the same edge, return the old word.

Reset
REQ-032 SHALL, on an edge with reset=1, clear the pipeline and queue, set outstanding=0, and drive rsp_valid=0, rsp_instr=0, rsp_pc=0 and rsp_err=0.
REQ-033 SHALL hold req_ready=0 while reset=1 and 1 in the first cycle after reset deasserts.
REQ-034 SHALL discard outstanding requests when reset asserts mid-operation; no response to them SHALL ever appear.
REQ-035 SHALL NOT alter memory contents on reset.

Verification
REQ-036 SHALL cover: preload word 0=32'h00500093 and word 1=32'h00A00113; LATENCY=2; request 0x0 then 0x4 on consecutive cycles with rsp_ready=1 -> responses (pc=0, 00500093) then (pc=4, 00A00113) on consecutive cycles, the first 2 cycles after acceptance, err=0.
REQ-037 SHALL cover: rsp_ready=0 while 6 requests are offered -> exactly 4 accepted, req_ready=0 afterwards, head response stable; release rsp_ready -> 4 in-order responses, then req_ready=1.
REQ-038 SHALL cover: request 0x2, then request 4*DEPTH_WORDS -> both responses have rsp_err=1 and rsp_instr=00000013.
REQ-039 SHALL cover: 3 requests outstanding, flush=1 together with req_valid=1 -> none of the 4 ever respond; rsp_valid=0 the next cycle; a new request 0x8 after the flush returns pc=8 only.
REQ-040 SHALL cover: reset=1 for 1 cycle with 2 outstanding -> no responses appear; the first post-reset request returns normally with its correct latency.

Source files
------------

// File: rtl/imem_responder.sv
// Preloadable instruction memory that answers fetches in order after a fixed
// pipeline latency, buffering results in a 4-entry queue; flush drops all in flight.
module imem_responder #(
    parameter int XLEN        = 64,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic            flush,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_instr,
    output logic [XLEN-1:0] rsp_pc,
    output logic            rsp_err,
    input  logic            load_we,
    input  logic [XLEN-1:0] load_addr,
    input  logic [31:0]     load_data
);

    localparam int              AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [XLEN-1:0] LP_DEPTH = XLEN'(DEPTH_WORDS);
    localparam logic [31:0]     LP_NOP   = 32'h0000_0013;
    localparam int              QD       = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            err;
    } fetch_t;

    logic [31:0]     r_mem [DEPTH_WORDS];
    fetch_t          r_q [QD];
    logic [1:0]      r_wr_ptr;
    logic [1:0]      r_rd_ptr;
    logic [2:0]      r_q_count;
    logic [2:0]      r_outstanding;

    logic            w_clear;
    logic            w_accept;
    logic            w_complete;
    logic            w_push_valid;
    logic            w_req_in_range;
    logic            w_load_in_range;
    logic            w_unused_load_lsb;
    logic [XLEN-1:0] w_req_word;
    logic [XLEN-1:0] w_load_word;
    fetch_t          w_fetch;
    fetch_t          w_push_data;
    fetch_t          w_head;

    assign w_clear    = reset | flush;
    assign req_ready  = (r_outstanding < 3'd4) && !flush && !reset;
    assign w_accept   = req_valid && req_ready;
    assign rsp_valid  = (r_q_count != 3'd0);
    assign w_complete = rsp_valid && rsp_ready;

    assign w_req_word        = {2'b00, req_addr[XLEN-1:2]};
    assign w_load_word       = {2'b00, load_addr[XLEN-1:2]};
    assign w_req_in_range    = (w_req_word < LP_DEPTH);
    assign w_load_in_range   = (w_load_word < LP_DEPTH);
    assign w_unused_load_lsb = ^load_addr[1:0];

    always_comb begin
        // NOTE: every field gets a default first so no path through the block infers a latch.
        w_fetch.pc    = req_addr;
        w_fetch.instr = LP_NOP;
        w_fetch.err   = 1'b1;
        if ((req_addr[1:0] == 2'b00) && w_req_in_range) begin
            w_fetch.instr = r_mem[req_addr[AW+1:2]];
            w_fetch.err   = 1'b0;
        end
    end

    // NOTE: the memory array is deliberately not reset; its contents must survive reset.
    // NOTE: non-blocking write, so a fetch of the same word on this edge still reads the old value.
    always_ff @(posedge clk) begin
        if (load_we && w_load_in_range) begin
            r_mem[load_addr[AW+1:2]] <= load_data;
        end
    end

    // The accepting edge captures the word; LATENCY-1 further stages precede the queue.
    generate
        if (LATENCY == 1) begin : g_direct
            assign w_push_valid = w_accept;
            assign w_push_data  = w_fetch;
        end else begin : g_pipe
            logic   r_v [LATENCY-1];
            fetch_t r_d [LATENCY-1];

            always_ff @(posedge clk) begin
                if (w_clear) begin
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        r_v[i] <= 1'b0;
                    end
                end else begin
                    r_v[0] <= w_accept;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        r_v[i] <= r_v[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                r_d[0] <= w_fetch;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    r_d[i] <= r_d[i-1];
                end
            end

            assign w_push_valid = r_v[LATENCY-2];
            assign w_push_data  = r_d[LATENCY-2];
        end
    endgenerate

    // Outstanding is capped at the queue depth, so a push never finds the queue full.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_outstanding <= 3'd0;
        end else begin
            r_outstanding <= r_outstanding + 3'(w_accept) - 3'(w_complete);
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wr_ptr  <= 2'd0;
            r_rd_ptr  <= 2'd0;
            r_q_count <= 3'd0;
        end else begin
            if (w_push_valid) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_complete) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_q_count <= r_q_count + 3'(w_push_valid) - 3'(w_complete);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_valid) begin
            r_q[r_wr_ptr] <= w_push_data;
        end
    end

    // Outputs read as zero whenever no response is presented.
    assign w_head    = r_q[r_rd_ptr];
    assign rsp_instr = rsp_valid ? w_head.instr : 32'h0;
    assign rsp_pc    = rsp_valid ? w_head.pc    : '0;
    assign rsp_err   = rsp_valid ? w_head.err   : 1'b0;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: table-driven fetch stream plus directed
// back-pressure, flush, load-collision and reset sequences against a scoreboard.
module tb_imem_responder;

    localparam int XLEN  = 64;
    localparam int DEPTH = 16;
    localparam int LAT   = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            flush;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_instr;
    logic [XLEN-1:0] rsp_pc;
    logic            rsp_err;
    logic            load_we;
    logic [XLEN-1:0] load_addr;
    logic [31:0]     load_data;

    always #5 clk = ~clk;

    imem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr), .rsp_pc(rsp_pc), .rsp_err(rsp_err), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        err;
        int          acc_cyc;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          n_acc    = 0;
    int          n_done   = 0;
    int          last_acc = 0;
    int          last_done = 0;
    logic [63:0] last_pc  = '0;
    logic [31:0] drv_instr;
    logic        drv_err;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_val(input int i);
        if (i == 0) return 32'h0050_0093;
        if (i == 1) return 32'h00A0_0113;
        return 32'hA000_0000 + 32'(i) * 32'h111;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pushes the driver's expectation on acceptance, pops and compares on completion.
    initial begin
        logic        held_v;
        logic [63:0] held_pc;
        logic [31:0] held_instr;
        logic        held_err;
        held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    check("hold_valid", rsp_valid, 1);
                    check("hold_pc", rsp_pc, held_pc);
                    check("hold_instr", rsp_instr, held_instr);
                    check("hold_err", rsp_err, held_err);
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rsp_pc", rsp_pc, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("rsp_pc", rsp_pc, e.pc);
                        check("rsp_instr", rsp_instr, e.instr);
                        check("rsp_err", rsp_err, e.err);
                        check("latency_min", (cyc - e.acc_cyc) >= LAT, 1);
                    end
                    n_done++;
                    last_done = cyc;
                    last_pc   = rsp_pc;
                end
                held_v     = rsp_valid && !rsp_ready && !flush;
                held_pc    = rsp_pc;
                held_instr = rsp_instr;
                held_err   = rsp_err;
                if (flush) begin
                    sb.delete();
                end else if (req_valid && req_ready) begin
                    sb.push_back('{req_addr, drv_instr, drv_err, cyc});
                    n_acc++;
                    last_acc = cyc;
                end
            end
        end
    end

    task automatic send(input logic [63:0] a, input logic [31:0] ei, input logic ee);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        drv_instr = ei;
        drv_err   = ee;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_accepted", ok, 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic load(input logic [63:0] a, input logic [31:0] d);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_we = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int t = 0; t < 40 && n_done < target; t++) @(negedge clk);
        check("drain", n_done >= target, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        int   t_first, t_last, n0, d0;

        reset = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_ready = 1'b1;
        load_we = 1'b0; load_addr = '0; load_data = '0; drv_instr = '0; drv_err = 1'b0;

        // Reset state
        tick();
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_instr", rsp_instr, 0);
        check("rst_rsp_pc", rsp_pc, 0);
        check("rst_rsp_err", rsp_err, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);
        tick();
        for (int i = 0; i < DEPTH; i++) load(64'(4 * i), word_val(i));

        // Two back-to-back fetches, exact latency
        req_valid = 1'b1; req_addr = 64'h0; drv_instr = word_val(0); drv_err = 1'b0;
        @(negedge clk);
        check("t1_accept0", req_ready, 1);
        tick();
        req_addr = 64'h4; drv_instr = word_val(1);
        @(negedge clk);
        check("t1_not_yet", rsp_valid, 0);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("t1_valid0", rsp_valid, 1);
        check("t1_pc0", rsp_pc, 0);
        check("t1_instr0", rsp_instr, 32'h0050_0093);
        @(negedge clk);
        check("t1_valid1", rsp_valid, 1);
        check("t1_pc1", rsp_pc, 4);
        check("t1_instr1", rsp_instr, 32'h00A0_0113);
        check("t1_err1", rsp_err, 0);
        @(negedge clk);
        check("t1_idle", rsp_valid, 0);
        tick();

        // Streaming table: aligned, last word, out of range, misaligned, high address
        tbl[0] = '{64'h8,  word_val(2),  1'b0};
        tbl[1] = '{64'hC,  word_val(3),  1'b0};
        tbl[2] = '{64'h3C, word_val(15), 1'b0};
        tbl[3] = '{64'h40, NOP,          1'b1};
        tbl[4] = '{64'h2,  NOP,          1'b1};
        tbl[5] = '{64'h1,  NOP,          1'b1};
        tbl[6] = '{64'h10, word_val(4),  1'b0};
        tbl[7] = '{64'h8000_0000_0000_0000, NOP, 1'b1};
        tbl[8] = '{64'h14, word_val(5),  1'b0};
        tbl[9] = '{64'h3F, NOP,          1'b1};
        d0 = n_done;
        t_first = 0;
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].addr, tbl[i].instr, tbl[i].err);
            if (i == 0) t_first = last_acc;
        end
        t_last = last_acc;
        check("tbl_back_to_back", t_last - t_first, 9);
        wait_done(d0 + 10);
        check("tbl_throughput", last_done - t_first, 9 + LAT);
        tick();

        // Back-pressure: six offered, four accepted, head held
        rsp_ready = 1'b0;
        n0 = n_acc;
        d0 = n_done;
        for (int k = 0; k < 6; k++) begin
            req_valid = 1'b1; req_addr = 64'(4 * k); drv_instr = word_val(k); drv_err = 1'b0;
            tick();
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", n_acc - n0, 4);
        check("bp_ready_low", req_ready, 0);
        check("bp_head_valid", rsp_valid, 1);
        repeat (3) @(negedge clk);
        check("bp_head_pc", rsp_pc, 0);
        check("bp_ready_still_low", req_ready, 0);
        tick();
        rsp_ready = 1'b1;
        wait_done(d0 + 4);
        @(negedge clk);
        check("bp_ready_back", req_ready, 1);
        tick();

        // Flush with three outstanding and a request offered on the flush edge
        rsp_ready = 1'b0;
        send(64'h0, word_val(0), 1'b0);
        send(64'h4, word_val(1), 1'b0);
        send(64'h8, word_val(2), 1'b0);
        flush = 1'b1; req_valid = 1'b1; req_addr = 64'h30; drv_instr = word_val(12);
        @(negedge clk);
        check("flush_ready_low", req_ready, 0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("flush_rsp_gone", rsp_valid, 0);
        tick();
        rsp_ready = 1'b1;
        d0 = n_done;
        repeat (8) @(negedge clk);
        check("flush_silent", n_done - d0, 0);
        tick();
        send(64'h8, word_val(2), 1'b0);
        wait_done(d0 + 1);
        check("flush_new_pc", last_pc, 8);
        repeat (4) @(negedge clk);
        check("flush_only_one", n_done - d0, 1);
        tick();

        // Flush on the same edge as a completing response: that one is delivered
        d0 = n_done;
        send(64'h0, word_val(0), 1'b0);
        send(64'h4, word_val(1), 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (6) @(negedge clk);
        check("flush_cmp_count", n_done - d0, 1);
        check("flush_cmp_pc", last_pc, 0);
        tick();

        // Load colliding with a fetch, out-of-range load, load address low bits ignored
        d0 = n_done;
        load_we = 1'b1; load_addr = 64'h1C; load_data = 32'hDEAD_BEEF;
        send(64'h1C, word_val(7), 1'b0);
        load_we = 1'b0;
        send(64'h1C, 32'hDEAD_BEEF, 1'b0);
        load(64'h40, 32'h1234_5678);
        send(64'h0, word_val(0), 1'b0);
        load(64'h23, 32'hCAFE_F00D);
        send(64'h20, 32'hCAFE_F00D, 1'b0);
        wait_done(d0 + 4);
        tick();

        // Reset with two outstanding: they vanish, memory survives, latency intact
        rsp_ready = 1'b0;
        send(64'h0, word_val(0), 1'b0);
        send(64'h4, word_val(1), 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ready_low", req_ready, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_pc", rsp_pc, 0);
        tick();
        rsp_ready = 1'b1;
        d0 = n_done;
        repeat (6) @(negedge clk);
        check("mid_rst_silent", n_done - d0, 0);
        tick();
        send(64'h4, word_val(1), 1'b0);
        wait_done(d0 + 1);
        check("mid_rst_latency", last_done - last_acc, LAT);
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
